conv_window_accumulator: RTL

Sequential accumulation stage directly downstream of `Multiplier` in the convolution datapath. It consumes one product per accepted handshake and sums `KERNEL_SIZE` products plus a bias into one convolution output. It applies optional ReLU, saturates the result to the feature-map width, and presents it on a valid/ready output port to the pooling/feature-map buffer stage.

---
 rtl/conv_window_accumulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/conv_window_accumulator.sv
// conv_window_accumulator: sums KERNEL_SIZE signed products plus a bias into
// one convolution result, applies optional ReLU, saturates to OUT_WIDTH and
// presents it on a valid/ready port.
module conv_window_accumulator #(
    parameter int unsigned PROD_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH   = 16,
    parameter int unsigned KERNEL_SIZE = 9,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter bit          RELU        = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic [PROD_WIDTH-1:0]                prod,
    input  logic                                 prod_valid,
    output logic                                 prod_ready,
    input  logic [ACC_WIDTH-1:0]                 bias,
    output logic [OUT_WIDTH-1:0]                 out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(KERNEL_SIZE+1)-1:0]     count,
    output logic                                 busy
);

    localparam int unsigned CNT_WIDTH = $clog2(KERNEL_SIZE + 1);

    // Saturation bounds expressed at accumulator width for signed compares.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]          count_q, count_d;
    logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;

    logic                          accept_c;
    logic signed [ACC_WIDTH-1:0]   prod_ext_c;
    logic signed [ACC_WIDTH-1:0]   base_c;
    logic signed [ACC_WIDTH-1:0]   sum_c;

    // ReLU then clamp of the final window sum to the output range.
    function automatic logic [OUT_WIDTH-1:0] convert(input logic signed [ACC_WIDTH-1:0] v);
        logic [OUT_WIDTH-1:0] r;
        if (RELU && v[ACC_WIDTH-1]) begin
            r = '0;
        end else if (v > SAT_MAX) begin
            r = OUT_WIDTH'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            r = OUT_WIDTH'(SAT_MIN);
        end else begin
            r = OUT_WIDTH'(v);
        end
        return r;
    endfunction

    // Handshake outputs decode straight from the state register.
    assign prod_ready = rst_n & (state_q != ST_OUTPUT);
    assign out_valid  = (state_q == ST_OUTPUT);
    assign busy       = (state_q != ST_IDLE);
    assign count      = count_q;
    assign out_data   = out_data_q;

    // Sign-extended product added to bias (first product) or running sum.
    assign accept_c   = prod_valid & prod_ready;
    assign prod_ext_c = ACC_WIDTH'($signed(prod));
    assign base_c     = (state_q == ST_IDLE) ? $signed(bias) : acc_q;
    assign sum_c      = base_c + prod_ext_c;

    // Next-state, accumulator, counter and result capture.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        out_data_d = out_data_q;

        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        acc_d   = sum_c;
                        count_d = CNT_WIDTH'(1);
                        if (KERNEL_SIZE == 1) begin
                            state_d    = ST_OUTPUT;
                            out_data_d = convert(sum_c);
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept_c) begin
                        acc_d   = sum_c;
                        count_d = count_q + CNT_WIDTH'(1);
                        if (count_q == CNT_WIDTH'(KERNEL_SIZE - 1)) begin
                            state_d    = ST_OUTPUT;
                            out_data_d = convert(sum_c);
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
